// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: takes a parallel word over valid/ready and shifts it
// onto tx_out as start bit, LSB-first data, optional parity bit and stop bit(s).
// Bit timing is derived from a shared 16x baud strobe, 16 ticks per bit.
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_16x,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [3:0]           tick_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 parity_bit;
  logic                 stop_cnt;

  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;

  // Frame sequencer: handshake capture, tick counting, bit advance and line drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      tx_done    <= 1'b0;
      tick_cnt   <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      parity_bit <= 1'b0;
      stop_cnt   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (tx_valid) begin
          // Parity is taken from the word as accepted, since shreg is consumed
          // as the data bits go out.
          shreg      <= tx_data;
          parity_bit <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
          state      <= START;
          tx_out     <= 1'b0;
          tick_cnt   <= '0;
          bit_idx    <= '0;
          stop_cnt   <= 1'b0;
        end
      end else if (tick_16x) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd15) begin
          case (state)
            START: begin
              state   <= DATA;
              tx_out  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= '0;
            end
            DATA: begin
              if (bit_idx == LAST_IDX) begin
                if (PARITY_EN != 0) begin
                  state  <= PARITY;
                  tx_out <= parity_bit;
                end else begin
                  state    <= STOP;
                  tx_out   <= 1'b1;
                  stop_cnt <= 1'b0;
                end
              end else begin
                tx_out  <= shreg[0];
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + IDX_W'(1);
              end
            end
            PARITY: begin
              state    <= STOP;
              tx_out   <= 1'b1;
              stop_cnt <= 1'b0;
            end
            STOP: begin
              if (stop_cnt == LAST_STOP) begin
                state   <= IDLE;
                tx_done <= 1'b1;
              end else begin
                stop_cnt <= stop_cnt + 1'b1;
              end
            end
            default: begin
              state  <= IDLE;
              tx_out <= 1'b1;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: five parameterisations share clock, tick and reset;
// one is selected at a time. Sends push expected frames into a queue; a negedge
// monitor pops them and checks the line tick by tick against a frame model.
module tb_uart_tx_serializer;

  typedef struct {
    logic [7:0] d;
    int         cfg;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       tick_16x;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] sel;

  logic [4:0] v_out, v_rdy, v_busy, v_done;
  logic tx_out, tx_ready, tx_busy, tx_done;

  assign tx_out   = v_out[sel];
  assign tx_ready = v_rdy[sel];
  assign tx_busy  = v_busy[sel];
  assign tx_done  = v_done[sel];

  int tests = 0;
  int fails = 0;
  int pushed = 0;
  int aborted = 0;
  int done_seen = 0;
  int tick_div = 4;

  exp_t q[$];
  bit   in_frame = 0;
  bit   exp_bits[16];
  int   nbits;

  // cfg 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, 4: 5O2
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tick_16x(tick_16x), .tx_data(tx_data),
    .tx_valid(tx_valid && (sel == 3'd0)), .tx_ready(v_rdy[0]), .tx_out(v_out[0]),
    .tx_busy(v_busy[0]), .tx_done(v_done[0]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tick_16x(tick_16x), .tx_data(tx_data),
    .tx_valid(tx_valid && (sel == 3'd1)), .tx_ready(v_rdy[1]), .tx_out(v_out[1]),
    .tx_busy(v_busy[1]), .tx_done(v_done[1]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tick_16x(tick_16x), .tx_data(tx_data),
    .tx_valid(tx_valid && (sel == 3'd2)), .tx_ready(v_rdy[2]), .tx_out(v_out[2]),
    .tx_busy(v_busy[2]), .tx_done(v_done[2]));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .tick_16x(tick_16x), .tx_data(tx_data),
    .tx_valid(tx_valid && (sel == 3'd3)), .tx_ready(v_rdy[3]), .tx_out(v_out[3]),
    .tx_busy(v_busy[3]), .tx_done(v_done[3]));
  uart_tx_serializer #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_5o2 (
    .clk(clk), .rst(rst), .tick_16x(tick_16x), .tx_data(tx_data[4:0]),
    .tx_valid(tx_valid && (sel == 3'd4)), .tx_ready(v_rdy[4]), .tx_out(v_out[4]),
    .tx_busy(v_busy[4]), .tx_done(v_done[4]));

  function automatic int cfg_db(input int k);
    return (k == 4) ? 5 : 8;
  endfunction
  function automatic bit cfg_pen(input int k);
    return (k == 1) || (k == 2) || (k == 4);
  endfunction
  function automatic bit cfg_odd(input int k);
    return (k == 2) || (k == 4);
  endfunction
  function automatic int cfg_stop(input int k);
    return ((k == 3) || (k == 4)) ? 2 : 1;
  endfunction

  // Expected line: one entry per bit period, start, data LSB first, parity, stops.
  task automatic load_model(input exp_t e);
    int ones;
    ones = 0;
    nbits = 0;
    exp_bits[nbits] = 1'b0;
    nbits = nbits + 1;
    for (int i = 0; i < cfg_db(e.cfg); i++) begin
      exp_bits[nbits] = e.d[i];
      nbits = nbits + 1;
      ones = ones + int'(e.d[i]);
    end
    if (cfg_pen(e.cfg)) begin
      // even: total ones (data+parity) even; odd: total ones odd
      exp_bits[nbits] = ((ones % 2) == 1) ^ cfg_odd(e.cfg);
      nbits = nbits + 1;
    end
    for (int s = 0; s < cfg_stop(e.cfg); s++) begin
      exp_bits[nbits] = 1'b1;
      nbits = nbits + 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int tcnt;
    tcnt = 0;
    tick_16x = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt++;
      if (tcnt >= tick_div) begin
        tcnt = 0;
        tick_16x = 1'b1;
      end else begin
        tick_16x = 1'b0;
      end
    end
  end

  // Monitor: frame starts when the line drops; each negedge the line must hold
  // the bit for the number of ticks seen so far; done must pulse after the last tick.
  initial begin
    exp_t cur;
    int   ticks;
    int   frame_err;
    int   bad_tick;
    bit   bad_got;
    bit   bad_want;
    bit   orphan;
    ticks = 0; frame_err = 0; bad_tick = 0; bad_got = 0; bad_want = 0; orphan = 0;
    cur = '{d: 8'h00, cfg: 0};
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_seen++;
      if (rst !== 1'b0) begin
        in_frame = 0;
        orphan = 0;
        continue;
      end
      if (tx_out === 1'b1) orphan = 0;
      if (!in_frame && !orphan && tx_out === 1'b0) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          orphan = 1;
          $display("FAIL unexpected_frame: line low with no frame queued, cfg=%0d", sel);
        end else begin
          cur = q.pop_front();
          load_model(cur);
          in_frame = 1;
          ticks = 0;
          frame_err = 0;
        end
      end
      if (in_frame) begin
        if (ticks == nbits * 16) begin
          tests++;
          if (frame_err != 0 || tx_done !== 1'b1 || tx_out !== 1'b1 || tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL frame cfg=%0d data=%0h: errs=%0d first at tick %0d line=%0b expected %0b; end done=%0b out=%0b ready=%0b expected 1,1,1",
                     cur.cfg, cur.d, frame_err, bad_tick, bad_got, bad_want, tx_done, tx_out, tx_ready);
          end
          in_frame = 0;
        end else begin
          if (tx_out !== exp_bits[ticks/16] || tx_busy !== 1'b1 || tx_ready !== 1'b0 ||
              tx_done !== 1'b0) begin
            if (frame_err == 0) begin
              bad_tick = ticks;
              bad_got  = tx_out;
              bad_want = exp_bits[ticks/16];
            end
            frame_err++;
          end
          if (tick_16x === 1'b1) ticks++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input bit chk_b2b);
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_ready === 1'b1) break;
      n++;
      if (n > 20000) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: tx_ready stayed %0b, required 1", tx_ready);
        return;
      end
    end
    if (chk_b2b) chk("b2b_done_at_accept", 32'(tx_done), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    q.push_back('{d: d, cfg: int'(sel)});
    pushed++;
    #1;
    chk("accept_line_low", 32'(tx_out), 32'd0);
    chk("accept_busy", 32'(tx_busy), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_frame || q.size() != 0 || tx_ready !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 20000) begin
        tests++;
        fails++;
        $display("FAIL idle_timeout: frame still pending, queue=%0d in_frame=%0b required 0,0", q.size(), in_frame);
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    int bad;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    sel = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_line", 32'(tx_out), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;

    // 8N1 0xA5
    send(8'hA5, 1'b0);
    tx_valid = 1'b0;
    wait_idle();

    // even / odd parity on 0x07
    sel = 3'd1;
    send(8'h07, 1'b0);
    tx_valid = 1'b0;
    wait_idle();
    sel = 3'd2;
    send(8'h07, 1'b0);
    tx_valid = 1'b0;
    wait_idle();

    // back-to-back with valid held
    sel = 3'd0;
    send(8'h55, 1'b0);
    send(8'h0F, 1'b1);
    tx_valid = 1'b0;
    wait_idle();

    // reset during data bit 3 of 0xFF
    send(8'hFF, 1'b0);
    tx_valid = 1'b0;
    n = 0;
    while (n < 72) begin
      @(negedge clk);
      if (tick_16x === 1'b1) n++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    d0 = done_seen;
    @(posedge clk);
    #1;
    rst = 1'b0;
    aborted++;
    chk("abort_line", 32'(tx_out), 32'd1);
    chk("abort_ready", 32'(tx_ready), 32'd1);
    chk("abort_busy", 32'(tx_busy), 32'd0);
    chk("abort_done", 32'(tx_done), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_seen - d0), 32'd0);
    send(8'h5A, 1'b0);
    tx_valid = 1'b0;
    wait_idle();

    // valid pulse while busy is ignored
    d0 = done_seen;
    send(8'h3C, 1'b0);
    tx_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("busy_ready_low", 32'(tx_ready), 32'd0);
    tx_data = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_idle();
    chk("busy_single_done", 32'(done_seen - d0), 32'd1);

    // two stop bits
    sel = 3'd3;
    send(8'h81, 1'b0);
    tx_valid = 1'b0;
    wait_idle();

    // ticks arriving while idle leave the line alone
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("idle_ticks_ignored", 32'(bad), 32'd0);

    // randomized traffic over every configuration
    for (int k = 0; k < 5; k++) begin
      sel = 3'(k);
      for (int i = 0; i < 6; i++) begin
        tick_div = int'($urandom_range(2, 4));
        send(8'($urandom), 1'b0);
        if ($urandom_range(0, 1) == 0) begin
          tx_valid = 1'b0;
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
        end
      end
      tx_valid = 1'b0;
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("done_count", 32'(done_seen), 32'(pushed - aborted));
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
